wb_port_arbiter: RTL

//  Shares the single regfile write port between three writers: the ALU writeback, the overflow status write to the status register, and the multdiv unit (MDU).

---
 rtl/wb_port_arbiter.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single regfile write port between the ALU writeback, the
//   overflow status write to rstatus, and the multdiv unit (MDU). The
//   two-write overflow sequence and the buffered MDU result are serialised
//   onto the port. stall freezes the processor while the port is busy.
//
// Optional feature macro: WB_OVF_ZERO_RD_EN
//   defined   : an overflow writes rd<=0, then rstatus<=code in a STATUS
//               cycle (stall high for that one cycle).
//   undefined : the rd write is suppressed; rstatus<=code uses the ALU slot
//               directly, STATUS is never entered and overflow never stalls.
//
// Ports
//   clock, reset        processor clock; synchronous active-low reset
//   alu_we/rd/data      ALU writeback request (ignored while stall=1)
//   alu_ovf/ovf_code    overflow flag and status code for this request
//   mdu_valid/rd/data   MDU result offer
//   mdu_ready           1-entry MDU buffer is empty
//   stall               processor holds PC/pipeline and re-presents request
//   wr_en/reg/data      registered regfile write port
//   state_dbg           current arbiter FSM state (0 IDLE, 1 STATUS, 2 FORCE)
//
// Handshake: an MDU result transfers on a rising edge where mdu_valid and
// mdu_ready are both 1; mdu_ready depends only on registered state. An ALU
// request is taken on any rising edge where alu_we=1 and stall=0.
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DATA_BITS    = 32,
  parameter int REG_BITS     = 5,
  parameter int STATUS_REG   = 30,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alu_we,
  input  logic [REG_BITS-1:0]  alu_rd,
  input  logic [DATA_BITS-1:0] alu_data,
  input  logic                 alu_ovf,
  input  logic [DATA_BITS-1:0] alu_ovf_code,
  input  logic                 mdu_valid,
  input  logic [REG_BITS-1:0]  mdu_rd,
  input  logic [DATA_BITS-1:0] mdu_data,
  output logic                 mdu_ready,
  output logic                 stall,
  output logic                 wr_en,
  output logic [REG_BITS-1:0]  wr_reg,
  output logic [DATA_BITS-1:0] wr_data,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STATUS = 2'd1,
    S_FORCE  = 2'd2
  } state_e;

  localparam logic [3:0]          LIMIT = 4'(STARVE_LIMIT);
  localparam logic [REG_BITS-1:0] SREG  = REG_BITS'(STATUS_REG);

  state_e                 state_q, state_d;
  logic                   buf_full_q, buf_full_d;
  logic [REG_BITS-1:0]    buf_rd_q, buf_rd_d;
  logic [DATA_BITS-1:0]   buf_data_q, buf_data_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [REG_BITS-1:0]    wr_reg_q, wr_reg_d;
  logic [DATA_BITS-1:0]   wr_data_q, wr_data_d;
`ifdef WB_OVF_ZERO_RD_EN
  logic [DATA_BITS-1:0]   code_q, code_d;
`endif

  logic                   we;
  logic                   drain;
  logic                   starve;

  // The counter saturates at LIMIT, and nothing can drain the buffer in
  // STATUS, so a starve seen in IDLE is still visible in the following STATUS.
  assign starve = buf_full_q && (cnt_q == LIMIT);

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_rd_d   = buf_rd_q;
    buf_data_d = buf_data_q;
    cnt_d      = cnt_q;
`ifdef WB_OVF_ZERO_RD_EN
    code_d     = code_q;
`endif
    we         = 1'b0;
    wr_reg_d   = '0;
    wr_data_d  = '0;
    drain      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (alu_we) begin
          we = 1'b1;
          if (alu_ovf) begin
`ifdef WB_OVF_ZERO_RD_EN
            wr_reg_d  = alu_rd;
            wr_data_d = '0;
            code_d    = alu_ovf_code;
            state_d   = S_STATUS;
`else
            wr_reg_d  = SREG;
            wr_data_d = alu_ovf_code;
            state_d   = starve ? S_FORCE : S_IDLE;
`endif
          end else begin
            wr_reg_d  = alu_rd;
            wr_data_d = alu_data;
            state_d   = starve ? S_FORCE : S_IDLE;
          end
        end else if (buf_full_q) begin
          // Free slot: the buffered MDU result drains without stalling.
          we        = 1'b1;
          wr_reg_d  = buf_rd_q;
          wr_data_d = buf_data_q;
          drain     = 1'b1;
        end
      end
      S_STATUS: begin
        we       = 1'b1;
        wr_reg_d = SREG;
`ifdef WB_OVF_ZERO_RD_EN
        wr_data_d = code_q;
`endif
        state_d  = starve ? S_FORCE : S_IDLE;
      end
      S_FORCE: begin
        we        = 1'b1;
        wr_reg_d  = buf_rd_q;
        wr_data_d = buf_data_q;
        drain     = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Load only while empty and drain only while full, so both never
    // happen in the same cycle.
    if (drain) begin
      buf_full_d = 1'b0;
      cnt_d      = '0;
    end else if (buf_full_q) begin
      if (cnt_q != LIMIT) cnt_d = cnt_q + 4'd1;
    end else if (mdu_valid) begin
      buf_full_d = 1'b1;
      buf_rd_d   = mdu_rd;
      buf_data_d = mdu_data;
      cnt_d      = '0;
    end

    wr_en_d = we && (wr_reg_d != '0);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      buf_full_q <= 1'b0;
      buf_rd_q   <= '0;
      buf_data_q <= '0;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_reg_q   <= '0;
      wr_data_q  <= '0;
`ifdef WB_OVF_ZERO_RD_EN
      code_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_rd_q   <= buf_rd_d;
      buf_data_q <= buf_data_d;
      cnt_q      <= cnt_d;
      wr_en_q    <= wr_en_d;
      wr_reg_q   <= wr_reg_d;
      wr_data_q  <= wr_data_d;
`ifdef WB_OVF_ZERO_RD_EN
      code_q     <= code_d;
`endif
    end
  end

  assign stall     = (state_q == S_STATUS) || (state_q == S_FORCE);
  assign mdu_ready = !buf_full_q;
  assign wr_en     = wr_en_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign state_dbg = state_q;

endmodule
